// File: rtl/draw_score_pkg.sv
// Shared geometry, colour constants and the 8x16 hex glyph font for draw_score.
package draw_score_pkg;

  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 32;
  localparam int CELL_W  = 18;
  localparam int SCALE   = 2;

  localparam logic [3:0] FG = 4'hF;
  localparam logic [3:0] BG = 4'h0;

  // FONT[nibble][rom_row]; bit 7 is the leftmost pixel column.
  localparam logic [7:0] FONT [16][16] = '{
    '{8'h7C,8'hC6,8'hC6,8'hCE,8'hDE,8'hF6,8'hE6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00},
    '{8'hF8,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'h18,8'hFF,8'h00,8'h00},
    '{8'h7C,8'hC6,8'h06,8'h06,8'h0C,8'h18,8'h30,8'h60,8'hC0,8'hC0,8'hC0,8'hC6,8'hC6,8'hFE,8'h00,8'h00},
    '{8'h7C,8'hC6,8'h06,8'h06,8'h06,8'h3C,8'h06,8'h06,8'h06,8'h06,8'h06,8'hC6,8'hC6,8'h7C,8'h00,8'h00},
    '{8'h0C,8'h1C,8'h3C,8'h6C,8'hCC,8'hCC,8'hFE,8'h0C,8'h0C,8'h0C,8'h0C,8'h0C,8'h0C,8'h1E,8'h00,8'h00},
    '{8'hFE,8'hC0,8'hC0,8'hC0,8'hFC,8'h06,8'h06,8'h06,8'h06,8'h06,8'h06,8'hC6,8'hC6,8'h7C,8'h00,8'h00},
    '{8'h38,8'h60,8'hC0,8'hC0,8'hFC,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00},
    '{8'hFE,8'hC6,8'h06,8'h0C,8'h18,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h30,8'h00,8'h00},
    '{8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h7C,8'h00,8'h00},
    '{8'h7C,8'hC6,8'hC6,8'hC6,8'hC6,8'h7E,8'h06,8'h06,8'h06,8'h06,8'h06,8'h06,8'h0C,8'h78,8'h00,8'h00},
    '{8'h10,8'h38,8'h6C,8'hC6,8'hC6,8'hC6,8'hFE,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'hC6,8'h00,8'h00},
    '{8'hFC,8'h66,8'h66,8'h66,8'h66,8'h7C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'hFC,8'h00,8'h00},
    '{8'h3C,8'h66,8'hC2,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC0,8'hC2,8'h66,8'h3C,8'h00,8'h00},
    '{8'hF8,8'h6C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h66,8'h6C,8'hF8,8'h00,8'h00},
    '{8'hFE,8'h66,8'h62,8'h68,8'h78,8'h68,8'h60,8'h60,8'h60,8'h60,8'h60,8'h62,8'h66,8'hFE,8'h00,8'h00},
    '{8'hFE,8'h66,8'h62,8'h68,8'h78,8'h68,8'h60,8'h60,8'h60,8'h60,8'h60,8'h60,8'h60,8'hF0,8'h00,8'h00}
  };

endpackage

// File: rtl/draw_score_font_rom.sv
// Combinational glyph lookup: (nibble, rom row) -> 8-pixel row bitmap, MSB leftmost.
module score_font_rom
  import draw_score_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic [3:0] i_row,
  output logic [7:0] o_bits
);

  assign o_bits = FONT[i_nibble][i_row];

endmodule

// File: rtl/draw_score.sv
// Hex score overlay: maps a pixel offset to a registered colour and draw-enable (1-clock latency).
// Optional leading-zero blanking is enabled by defining DRAW_SCORE_LEADING_ZERO_BLANK_EN.
module draw_score
  import draw_score_pkg::*;
#(
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [9:0]            offsetX,
  input  logic [8:0]            offsetY,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [3:0]            Red,
  output logic [3:0]            Green,
  output logic [3:0]            Blue,
  output logic                  Draw
);

  logic [9:0] w_k;
  logic [4:0] w_c;
  logic       w_inside;
  logic [3:0] w_nibble;
  logic       w_blank;
  logic [7:0] w_bits;
  logic       w_pix;
  logic       w_draw;
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
  logic       w_zero_run;
`endif

  assign w_k = offsetX / 10'(CELL_W);
  assign w_c = 5'(offsetX % 10'(CELL_W));

  assign w_inside = (w_k < 10'(DIGITS)) && (w_c < 5'(GLYPH_W)) && (offsetY < 9'(GLYPH_H));

  // Select the nibble of cell k; the zero run tracks whether every cell up to k is zero.
  always_comb begin
    w_nibble = 4'd0;
    w_blank  = 1'b0;
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
    w_zero_run = 1'b1;
`endif
    for (int i = 0; i < DIGITS; i++) begin
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
      w_zero_run = w_zero_run && (digits[4*(DIGITS-1-i) +: 4] == 4'd0);
`endif
      if (w_k == 10'(i)) begin
        w_nibble = digits[4*(DIGITS-1-i) +: 4];
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
        w_blank  = w_zero_run && (i != DIGITS-1);
`endif
      end
    end
  end

  score_font_rom u_font (
    .i_nibble (w_nibble),
    .i_row    (offsetY[4:1]),
    .o_bits   (w_bits)
  );

  assign w_pix  = w_bits[3'd7 - w_c[3:1]];
  assign w_draw = w_inside && !w_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Draw  <= 1'b0;
      Red   <= BG;
      Green <= BG;
      Blue  <= BG;
    end else begin
      Draw  <= w_draw;
      Red   <= (w_draw && w_pix) ? FG : BG;
      Green <= (w_draw && w_pix) ? FG : BG;
      Blue  <= (w_draw && w_pix) ? FG : BG;
    end
  end

endmodule

// File: tb/tb_draw_score.sv
// Directed bench for draw_score: reset, geometry, glyph sweep, latency, leading-zero blanking.
module tb_draw_score;
  import draw_score_pkg::*;

  localparam int DIGITS = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  offsetX;
  logic [8:0]  offsetY;
  logic [39:0] digits;
  logic [3:0]  Red, Green, Blue;
  logic        Draw;
  logic [12:0] got;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  draw_score #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .offsetX (offsetX),
    .offsetY (offsetY),
    .digits  (digits),
    .Red     (Red),
    .Green   (Green),
    .Blue    (Blue),
    .Draw    (Draw)
  );

  assign got = {Draw, Red, Green, Blue};

  // Expected {Draw, R, G, B} for one pixel, built from the cell geometry and the font table.
  function automatic logic [12:0] ref_pixel(input logic [9:0] x, input logic [8:0] y,
                                            input logic [39:0] d);
    int k, c;
    logic [3:0] nib;
    logic [7:0] bits;
    logic blank;
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
    logic zrun;
`endif
    k = int'(x) / 18;
    c = int'(x) % 18;
    if (!(k < DIGITS && c < 16 && y < 9'd32)) return 13'h0000;
    nib = d[4*(DIGITS-1-k) +: 4];
    blank = 1'b0;
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
    zrun = 1'b1;
    for (int i = 0; i <= k; i++) zrun = zrun && (d[4*(DIGITS-1-i) +: 4] == 4'd0);
    blank = zrun && (k != DIGITS-1);
`endif
    if (blank) return 13'h0000;
    bits = FONT[nib][int'(y) / 2];
    return bits[7 - c/2] ? 13'h1FFF : 13'h1000;
  endfunction

  task automatic drive(input logic [9:0] x, input logic [8:0] y, input logic [39:0] d);
    @(negedge clk);
    offsetX = x;
    offsetY = y;
    digits  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(10'(i * 18), 9'(i), 40'h123456789A);
      checks++;
      if (got !== 13'h0000) begin
        errors++;
        $display("FAIL reset_hold i=%0d got=%h exp=0000", i, got);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    offsetX = 10'd0; offsetY = 9'd0; digits = 40'h123456789A;
    #1;
    checks++;
    if (got !== 13'h0000) begin
      errors++;
      $display("FAIL reset_release_pre got=%h exp=0000", got);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 13'h1FFF) begin
      errors++;
      $display("FAIL reset_release_first got=%h exp=1fff", got);
    end
    // Asynchronous reset in the middle of a frame clears outputs without a clock edge.
    drive(10'd6, 9'd2, 40'h123456789A);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (got !== 13'h0000) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0000", got);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_geometry;
    logic [9:0] xs [17] = '{10'd0, 10'd15, 10'd16, 10'd17, 10'd18, 10'd33, 10'd34, 10'd35,
                           10'd161, 10'd162, 10'd177, 10'd178, 10'd180, 10'd181, 10'd1023,
                           10'd0, 10'd5};
    logic [8:0] ys [17] = '{9'd0, 9'd31, 9'd0, 9'd0, 9'd0, 9'd31, 9'd0, 9'd0,
                           9'd10, 9'd0, 9'd0, 9'd0, 9'd0, 9'd5, 9'd0,
                           9'd32, 9'd511};
    logic       ed [17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      drive(xs[i], ys[i], 40'h123456789A);
      checks++;
      if (Draw !== ed[i]) begin
        errors++;
        $display("FAIL geometry x=%0d y=%0d draw=%b exp=%b", xs[i], ys[i], Draw, ed[i]);
      end
    end
  endtask

  task automatic test_glyph_points;
    logic [9:0]  xs [10] = '{10'd0, 10'd9, 10'd10, 10'd0, 10'd6, 10'd18, 10'd20, 10'd168,
                            10'd166, 10'd0};
    logic [8:0]  ys [10] = '{9'd0, 9'd1, 9'd0, 9'd2, 9'd2, 9'd0, 9'd0, 9'd0, 9'd0, 9'd30};
    logic [12:0] ex [10] = '{13'h1FFF, 13'h1FFF, 13'h1000, 13'h1000, 13'h1FFF, 13'h1000,
                            13'h1FFF, 13'h1FFF, 13'h1000, 13'h1000};
    for (int i = 0; i < 10; i++) begin
      drive(xs[i], ys[i], 40'h123456789A);
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL glyph_point x=%0d y=%0d got=%h exp=%h", xs[i], ys[i], got, ex[i]);
      end
    end
  endtask

  task automatic test_glyph_sweep(input logic [39:0] d);
    logic [12:0] exp_v;
    for (int y = 0; y < 33; y++) begin
      for (int x = 0; x < 182; x++) begin
        drive(10'(x), 9'(y), d);
        exp_v = ref_pixel(10'(x), 9'(y), d);
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL glyph_sweep d=%h x=%0d y=%0d got=%h exp=%h", d, x, y, got, exp_v);
        end
      end
    end
  endtask

  task automatic test_latency;
    drive(10'd16, 9'd0, 40'h123456789A);
    checks++;
    if (Draw !== 1'b0) begin
      errors++;
      $display("FAIL latency_gap draw=%b exp=0", Draw);
    end
    @(negedge clk);
    offsetX = 10'd0;
    #1;
    checks++;
    if (Draw !== 1'b0) begin
      errors++;
      $display("FAIL latency_early draw=%b exp=0", Draw);
    end
    @(posedge clk);
    #1;
    checks++;
    if (got !== 13'h1FFF) begin
      errors++;
      $display("FAIL latency_edge got=%h exp=1fff", got);
    end
  endtask

  task automatic test_blank;
    logic exp_d;
    for (int k = 0; k < DIGITS; k++) begin
      drive(10'(k * 18 + 2), 9'd4, 40'h0000000042);
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
      exp_d = (k >= 8);
`else
      exp_d = 1'b1;
`endif
      checks++;
      if (Draw !== exp_d) begin
        errors++;
        $display("FAIL blank_42 cell=%0d draw=%b exp=%b", k, Draw, exp_d);
      end
    end
    for (int k = 0; k < DIGITS; k++) begin
      drive(10'(k * 18 + 2), 9'd4, 40'h0000000000);
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
      exp_d = (k == 9);
`else
      exp_d = 1'b1;
`endif
      checks++;
      if (Draw !== exp_d) begin
        errors++;
        $display("FAIL blank_zero cell=%0d draw=%b exp=%b", k, Draw, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [39:0] ds [4] = '{40'h1000000000, 40'h0000000000, 40'hB000000000, 40'h0000000000};
    logic [12:0] ex [4];
    ex[0] = 13'h1FFF;
`ifdef DRAW_SCORE_LEADING_ZERO_BLANK_EN
    ex[1] = 13'h0000;
`else
    ex[1] = 13'h1000;
`endif
    ex[2] = 13'h1FFF;
    ex[3] = ex[1];
    for (int i = 0; i < 4; i++) begin
      drive(10'd0, 9'd0, ds[i]);
      checks++;
      if (got !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back i=%0d got=%h exp=%h", i, got, ex[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    offsetX = 10'd0;
    offsetY = 9'd0;
    digits = 40'h0;
    test_reset;
    test_geometry;
    test_glyph_points;
    test_latency;
    test_glyph_sweep(40'h123456789A);
    test_glyph_sweep(40'h0123456789);
    test_glyph_sweep(40'hABCDEFFEDC);
    test_blank;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_score.md
# draw_score

Renders a fixed-width row of hexadecimal digits as a pixel overlay for the VGA pipeline. It sits after `vga_controller`, which supplies the current pixel column and row. Given a pixel position relative to the score origin, it returns a registered colour and a draw-enable for the downstream mixer.

## Interface
- `DIGITS`, default 10: number of 4-bit hex digits shown.
- `clk` input, 1 bit: pixel clock, rising-edge.
- `reset` input, 1 bit: one clock; reset is asynchronous and active-high.
- `offsetX` input, 10 bits: pixel column relative to the score origin, unsigned.
- `offsetY` input, 9 bits: pixel row relative to the score origin, unsigned.
- `digits` input, 4*DIGITS bits: packed hex nibbles; the most-significant nibble is the leftmost digit.
- `Red` output, 4 bits: foreground colour component.
- `Green` output, 4 bits: foreground colour component.
- `Blue` output, 4 bits: foreground colour component.
- `Draw` output, 1 bit: pixel lies inside a digit glyph box.

## Operation
- Cell geometry:
  - Each digit occupies an 18-pixel-wide cell: a 16-pixel glyph followed by a 2-pixel gap.
  - Glyph height is 32 rows.
- Per-pixel decode:
  - digit index k = offsetX / 18; column c = offsetX % 18; row r = offsetY.
  - Nibble shown for k is `digits[4*(DIGITS-1-k) +: 4]`.
- Inside condition, all of:
  - k < DIGITS
  - c < 16
  - r < 32
- Font lookup:
  - Source is an 8x16 glyph ROM for values 0x0–0xF, scaled 2x in both axes.
  - ROM row = r>>1, ROM column = c>>1.
  - ROM bit 7 is the leftmost column.
- Outputs:
  - Inside and font bit set: `Draw`=1, `Red`/`Green`/`Blue` = 4'hF.
  - Inside and font bit clear: `Draw`=1, colour = 4'h0.
  - Outside: `Draw`=0, colour = 4'h0.
- Arithmetic:
  - Divide and modulo by 18 are computed combinationally on the 10-bit `offsetX`.
  - Any offset beyond DIGITS*18-1 columns or 31 rows is "outside".
  - No wrap-around.
- `digits` may change at any time. It is sampled in the same cycle as the coordinates it pairs with.

## Timing
- All outputs are registered.
- Latency is 1 clock: outputs after rising edge n reflect `offsetX`/`offsetY`/`digits` sampled at edge n.
- Reset value of every output is 0. Reset may assert mid-frame.
- The first valid output is produced on the first edge after `reset` deasserts.
- No handshake and no internal state beyond the output registers.

## Configuration
- `DRAW_SCORE_LEADING_ZERO_BLANK_EN` defined:
  - Digits of value 0 to the left of the first non-zero digit are blanked: `Draw`=0, colour 0.
  - The rightmost digit is always drawn, so an all-zero value shows a single "0".
- Undefined: every digit is drawn, including leading zeros.

## Structure
- Package `draw_score_pkg` holds:
  - Glyph geometry constants: GLYPH_W=16, GLYPH_H=32, CELL_W=18, SCALE=2.
  - Colour constants: FG=4'hF, BG=4'h0.
  - The 16x16x8 font table as a constant array.
- One sub-module, `score_font_rom`: combinational lookup (nibble, row[3:0]) -> 8-bit row bitmap.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset`=1 while sweeping the coordinates.
  - Required: `Draw`=0 and colour=0 throughout; after release, outputs track the input with 1-cycle latency.
- Geometry with `digits`=40'h123456789A:
  - Columns 0–15 and 18–33 at rows 0–31: `Draw`=1.
  - Columns 16, 17, 34, 35: `Draw`=0.
  - Column 180 and above: `Draw`=0.
  - Row 32: `Draw`=0.
- Glyph content:
  - Stimulus: raster sweep of rows 0–31, columns 0–179.
  - Required: each `Red`[0]&&`Draw` bitmap equals the package font for 1,2,…,9,A, each pixel doubled horizontally and vertically.
- All values: `digits`=40'h0123456789 then 40'hABCDEFFEDC. Every glyph matches the package font; the digit order is MSB leftmost.
- Latency:
  - Stimulus: step `offsetX` from 16 to 0 at row 0 with digit 1's top-left font bit set.
  - Required: `Draw` rises exactly one edge after the step.
- Leading-zero blanking with the macro defined:
  - `digits`=40'h0000000042: cells 0–7 have `Draw`=0; cells 8–9 are drawn.
  - `digits`=0: only cell 9 is drawn.
  - Without the macro, all 10 cells are drawn.
